vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Read side of the double-buffered VGA frame memory. Generates 640x480@60 raster timing from i_clk via a pixel-tick divider.
//  Drives the 8-bit frame coordinates o_pxlX/o_pxlY into the front buffer, samples the returned i_color, and emits aligned sync/DE/colour to the DAC pins.
//  Exports o_vblank and o_frame_start so software swaps buffers only during vertical blanking.
// PARAMETERS
//  CLK_DIV      2    i_clk cycles per pixel tick (50 MHz -> 25 MHz pixel rate)
//  RD_LAT       1    frame memory read latency in i_clk cycles, must be <= CLK_DIV-1 ($error at elaboration otherwise)
//  SCALE_SHIFT  2    screen-to-frame downscale, log2 (640x480 -> 160x120)
//  H_ACTIVE/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing, in pixels
//  V_ACTIVE/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing, in lines
// PORTS
//  i_clk          in   1   system clock, all logic on rising edge
//  i_reset        in   1   synchronous, active-high reset
//  i_color        in   vga_color_t   front-buffer pixel, valid RD_LAT cycles after o_pxlX/o_pxlY change
//  o_pxlX         out  8   frame column = h_cnt >> SCALE_SHIFT, truncated to 8 bits
//  o_pxlY         out  8   frame row    = v_cnt >> SCALE_SHIFT, truncated to 8 bits
//  o_hsync        out  1   horizontal sync, active low
//  o_vsync        out  1   vertical sync, active low
//  o_de           out  1   display enable, high on visible pixels
//  o_color        out  vga_color_t   pixel to DAC, forced to 0 when o_de=0
//  o_vblank       out  1   high while v_cnt >= V_ACTIVE
//  o_frame_start  out  1   one-i_clk pulse when the raster returns to (0,0)
// BEHAVIOUR
//  Reset values:
//   - pix_cnt, h_cnt and v_cnt are 0.
//   - o_pxlX/o_pxlY are 0.
//   - o_hsync and o_vsync are 1.
//   - o_de, o_color, o_vblank and o_frame_start are 0.
//   - Reset asserted mid-line or mid-frame takes effect on the next edge and restarts the raster at (0,0).
//  Pixel tick:
//   - pix_cnt counts 0..CLK_DIV-1 and wraps to 0.
//   - tick is high when pix_cnt == CLK_DIV-1.
//   - With CLK_DIV=1, tick is high on every cycle.
//  Counters (advance only on tick):
//   - h_cnt counts 0..H_TOTAL-1, H_TOTAL=800.
//   - v_cnt increments when h_cnt wraps, over 0..V_TOTAL-1, V_TOTAL=525.
//   - Both counters wrap to 0 together at the frame end.
//  Address stage:
//   - o_pxlX/o_pxlY are registered from the counters and update on the edge after tick, i.e. when pix_cnt returns to 0.
//   - In blanking they hold the clamped values min(h_cnt,H_ACTIVE-1)>>SCALE_SHIFT and min(v_cnt,V_ACTIVE-1)>>SCALE_SHIFT, so no out-of-range address reaches the memory.
//  Sample/output stage:
//   - On tick, i_color is registered into o_color. The address has been stable for CLK_DIV-1 >= RD_LAT cycles by then.
//   - On the same tick, the following are registered from the current counters:
//     - o_de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
//     - o_hsync = !(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
//     - o_vsync = !(V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC)
//     - o_vblank = (v_cnt >= V_ACTIVE)
//   - Result: o_color, o_de, o_hsync and o_vsync are mutually aligned, each exactly one pixel period behind its counter value.
//  o_frame_start: pulses for one i_clk cycle on the cycle after the tick on which h_cnt and v_cnt both wrap to 0.
//  Simultaneous events: an h wrap and a v wrap on the same tick are one frame wrap, producing one o_frame_start pulse.
//  No handshake: i_color is trusted every tick. A buffer swap mid-frame is not blocked here; software gates swaps with o_vblank.
// STRUCTURE
//  vga_pkg holds:
//   - vga_color_t (existing type)
//   - H_TOTAL, V_TOTAL and the sync-window localparams derived from the defaults
//  One sub-module, vga_axis_counter, parameterised ACTIVE/FP/SYNC/BP:
//   - inputs: i_clk, i_reset, i_en
//   - outputs: o_cnt, o_wrap, o_active, o_sync_n
//   - instanced twice: h with i_en=tick; v with i_en=tick&&h_wrap
//  The top level holds the divider, the address clamp/shift and the output registers.
// TESTING
//  1. Reset: hold i_reset 3 cycles -> all outputs at reset values; first tick at cycle CLK_DIV-1 after release.
//  2. Line timing (CLK_DIV=2):
//     - o_hsync low for exactly 192 i_clk cycles per 1600-cycle line.
//     - o_de high for 1280 cycles per visible line.
//  3. Frame timing:
//     - o_vsync low for 2 lines (3200 cycles).
//     - o_frame_start period is 840000 cycles.
//     - o_vblank high for 45 lines.
//  4. Scaling: h_cnt=4..7 -> o_pxlX=1; h_cnt=639 -> 159; v_cnt=479 -> o_pxlY=119; blanking h_cnt=700 -> o_pxlX held at 159.
//  5. Colour path:
//     - Model memory returning i_color=f(pxlX,pxlY) after RD_LAT=1 -> o_color matches f for every visible pixel, one pixel later.
//     - o_color=0 whenever o_de=0.
//  6. Mid-frame reset at v_cnt=200, h_cnt=300 -> next cycle counters are 0 and outputs are at reset values; next o_frame_start occurs 840000 cycles after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA types, default 640x480@60 timing and the frame-address helper.
// The read-side scanout and its axis counters import this package.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_color_t;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int unsigned V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

  // Clamp into the active area before downscaling so blanking never addresses past the frame.
  function automatic logic [7:0] frame_coord(input int unsigned cnt, input int unsigned active,
                                             input int unsigned shift);
    int unsigned clamped;
    clamped = (cnt < active) ? cnt : active - 1;
    return 8'(clamped >> shift);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active-area and sync-window decode.
// o_wrap flags the terminal count, i.e. the next enabled step returns to 0.
module vga_axis_counter #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned CNT_W  = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_active,
  output logic             o_sync_n
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_cnt <= '0;
    end else if (i_en) begin
      o_cnt <= o_wrap ? '0 : o_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_wrap   = (32'(o_cnt) == TOTAL - 1);
    o_active = (32'(o_cnt) < ACTIVE);
    o_sync_n = !((32'(o_cnt) >= ACTIVE + FP) && (32'(o_cnt) < ACTIVE + FP + SYNC));
  end

endmodule

// File: rtl/vga_scanout.sv
// Front-buffer read side: pixel-tick divider, raster counters, clamped frame address
// and the aligned sync/DE/colour output registers.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  vga_color_t i_color,
  output logic [7:0] o_pxlX,
  output logic [7:0] o_pxlY,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de,
  output vga_color_t o_color,
  output logic       o_vblank,
  output logic       o_frame_start
);

  localparam int unsigned PIX_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned V_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  // The sample tick must see data that has settled behind the address change.
  if (CLK_DIV == 0 || RD_LAT + 1 > CLK_DIV) begin : g_bad_rd_lat
    $error("vga_scanout: RD_LAT (%0d) must not exceed CLK_DIV-1 (CLK_DIV=%0d)", RD_LAT, CLK_DIV);
  end

  logic [PIX_W-1:0] pix_cnt;
  logic             tick;
  logic [H_W-1:0]   h_cnt, h_next;
  logic [V_W-1:0]   v_cnt, v_next;
  logic             h_wrap, h_active, h_sync_n;
  logic             v_wrap, v_active, v_sync_n;
  logic             v_en, visible;

  assign tick = (32'(pix_cnt) == CLK_DIV - 1);
  assign v_en = tick && h_wrap;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pix_cnt <= '0;
    end else begin
      pix_cnt <= tick ? '0 : pix_cnt + PIX_W'(1);
    end
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .CNT_W (H_W)
  ) u_h_axis (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (tick),
    .o_cnt   (h_cnt),
    .o_wrap  (h_wrap),
    .o_active(h_active),
    .o_sync_n(h_sync_n)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .CNT_W (V_W)
  ) u_v_axis (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (v_en),
    .o_cnt   (v_cnt),
    .o_wrap  (v_wrap),
    .o_active(v_active),
    .o_sync_n(v_sync_n)
  );

  // The address is loaded from the counters' next values so it changes together with them.
  always_comb begin
    h_next  = h_wrap ? '0 : h_cnt + H_W'(1);
    v_next  = v_cnt;
    if (h_wrap) begin
      v_next = v_wrap ? '0 : v_cnt + V_W'(1);
    end
    visible = h_active && v_active;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pxlX <= '0;
      o_pxlY <= '0;
    end else if (tick) begin
      o_pxlX <= frame_coord(32'(h_next), H_ACTIVE, SCALE_SHIFT);
      o_pxlY <= frame_coord(32'(v_next), V_ACTIVE, SCALE_SHIFT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_de          <= 1'b0;
      o_color       <= '0;
      o_vblank      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= tick && h_wrap && v_wrap;
      if (tick) begin
        o_de     <= visible;
        o_hsync  <= h_sync_n;
        o_vsync  <= v_sync_n;
        o_vblank <= !v_active;
        o_color  <= visible ? i_color : '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size 640x480 instance and a tiny-raster instance, both fed by
// random frame memories and compared every cycle against a closed-form raster model.
module tb_vga_scanout;
  import vga_pkg::*;

  localparam int Shift = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  vga_color_t col_a, col_b, ocol_a, ocol_b;
  logic [7:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, de_a, vb_a, fs_a;
  logic       hs_b, vs_b, de_b, vb_b, fs_b;

  logic [11:0] mem [256][256];
  longint ka = 0;
  longint kb = 0;
  int     vectors = 0;
  int     miscompares = 0;
  bit     chk_en = 1'b0;

  typedef struct packed {
    logic [7:0]  x;
    logic [7:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        vb;
    logic        fs;
    logic [11:0] col;
  } exp_t;

  vga_scanout u_dut_a (
    .i_clk        (clk),
    .i_reset      (rst_a),
    .i_color      (col_a),
    .o_pxlX       (x_a),
    .o_pxlY       (y_a),
    .o_hsync      (hs_a),
    .o_vsync      (vs_a),
    .o_de         (de_a),
    .o_color      (ocol_a),
    .o_vblank     (vb_a),
    .o_frame_start(fs_a)
  );

  vga_scanout #(
    .CLK_DIV    (3),
    .RD_LAT     (1),
    .SCALE_SHIFT(2),
    .H_ACTIVE   (16),
    .H_FP       (2),
    .H_SYNC     (3),
    .H_BP       (3),
    .V_ACTIVE   (8),
    .V_FP       (2),
    .V_SYNC     (2),
    .V_BP       (2)
  ) u_dut_b (
    .i_clk        (clk),
    .i_reset      (rst_b),
    .i_color      (col_b),
    .o_pxlX       (x_b),
    .o_pxlY       (y_b),
    .o_hsync      (hs_b),
    .o_vsync      (vs_b),
    .o_de         (de_b),
    .o_color      (ocol_b),
    .o_vblank     (vb_b),
    .o_frame_start(fs_b)
  );

  // One-cycle-latency frame memories plus cycle indices since the last reset edge.
  always @(posedge clk) begin
    col_a <= vga_color_t'(mem[y_a][x_a]);
    col_b <= vga_color_t'(mem[y_b][x_b]);
    ka    <= rst_a ? 64'd0 : ka + 64'd1;
    kb    <= rst_b ? 64'd0 : kb + 64'd1;
  end

  // Cycle k after reset shows pixel k/d on the address and pixel k/d-1 on the DAC outputs.
  function automatic exp_t model(input int d, input int ha, input int hfp, input int hsw,
                                 input int hbp, input int va, input int vfp, input int vsw,
                                 input int vbp, input longint k);
    exp_t   e;
    longint ht, vt, p, h, v, hq, vq, xq, yq;
    ht = longint'(ha + hfp + hsw + hbp);
    vt = longint'(va + vfp + vsw + vbp);
    p  = k / longint'(d);
    h  = p % ht;
    v  = (p / ht) % vt;
    e.x  = 8'(((h < longint'(ha)) ? h : longint'(ha - 1)) >> Shift);
    e.y  = 8'(((v < longint'(va)) ? v : longint'(va - 1)) >> Shift);
    e.fs = (k % longint'(d) == 64'd0) && (p > 64'd0) && (p % (ht * vt) == 64'd0);
    if (p == 64'd0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.de  = 1'b0;
      e.vb  = 1'b0;
      e.col = '0;
    end else begin
      hq   = (p - 64'd1) % ht;
      vq   = ((p - 64'd1) / ht) % vt;
      xq   = ((hq < longint'(ha)) ? hq : longint'(ha - 1)) >> Shift;
      yq   = ((vq < longint'(va)) ? vq : longint'(va - 1)) >> Shift;
      e.de = (hq < longint'(ha)) && (vq < longint'(va));
      e.hs = !((hq >= longint'(ha + hfp)) && (hq < longint'(ha + hfp + hsw)));
      e.vs = !((vq >= longint'(va + vfp)) && (vq < longint'(va + vfp + vsw)));
      e.vb = (vq >= longint'(va));
      e.col = e.de ? mem[8'(yq)][8'(xq)] : 12'd0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t e, input logic [7:0] x,
                           input logic [7:0] y, input logic hs, input logic vs, input logic de,
                           input logic vb, input logic fs, input logic [11:0] col);
    chk({tag, ".pxlX"}, 32'(x), 32'(e.x));
    chk({tag, ".pxlY"}, 32'(y), 32'(e.y));
    chk({tag, ".hsync"}, 32'(hs), 32'(e.hs));
    chk({tag, ".vsync"}, 32'(vs), 32'(e.vs));
    chk({tag, ".de"}, 32'(de), 32'(e.de));
    chk({tag, ".vblank"}, 32'(vb), 32'(e.vb));
    chk({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
    chk({tag, ".color"}, 32'(col), 32'(e.col));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut("a", model(2, DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP, DEF_V_ACTIVE,
                           DEF_V_FP, DEF_V_SYNC, DEF_V_BP, ka),
                x_a, y_a, hs_a, vs_a, de_a, vb_a, fs_a, ocol_a);
      check_dut("b", model(3, 16, 2, 3, 3, 8, 2, 2, 2, kb),
                x_b, y_b, hs_b, vs_b, de_b, vb_b, fs_b, ocol_b);
    end
  end

  task automatic wait_k(input bit use_b, input longint target);
    int n = 0;
    while (((use_b ? kb : ka) != target) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if ((use_b ? kb : ka) != target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_k: cycle index %0d never reached (use_b=%0d)", target, use_b);
    end
  endtask

  initial begin
    int hs_low, de_hi, vs_low, vb_hi, n;

    for (int y = 0; y < 256; y++) begin
      for (int x = 0; x < 256; x++) begin
        mem[y][x] = 12'($urandom);
      end
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    chk("rst_pxlX", 32'(x_a), 32'd0);
    chk("rst_pxlY", 32'(y_a), 32'd0);
    chk("rst_hsync", 32'(hs_a), 32'd1);
    chk("rst_vsync", 32'(vs_a), 32'd1);
    chk("rst_de", 32'(de_a), 32'd0);
    chk("rst_color", 32'(ocol_a), 32'd0);
    chk("rst_frame_start", 32'(fs_b), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Full-size raster: first tick, scaling and one complete line.
    wait_k(1'b0, 64'd1);
    chk("a_de_before_first_tick", 32'(de_a), 32'd0);
    wait_k(1'b0, 64'd2);
    chk("a_de_after_first_tick", 32'(de_a), 32'd1);
    wait_k(1'b0, 64'd8);
    chk("a_pxlX_h4", 32'(x_a), 32'd1);
    wait_k(1'b0, 64'd15);
    chk("a_pxlX_h7", 32'(x_a), 32'd1);
    wait_k(1'b0, 64'd1278);
    chk("a_pxlX_h639", 32'(x_a), 32'd159);
    wait_k(1'b0, 64'd1400);
    chk("a_pxlX_h700", 32'(x_a), 32'd159);
    wait_k(1'b0, 64'd1600);
    hs_low = 0;
    de_hi  = 0;
    for (int i = 0; i < 1600; i++) begin
      if (!hs_a) hs_low++;
      if (de_a) de_hi++;
      @(negedge clk);
    end
    chk("a_hsync_low_cycles", 32'(hs_low), 32'd192);
    chk("a_de_high_cycles", 32'(de_hi), 32'd1280);

    // Small raster: one full frame period measured pulse to pulse.
    n = 0;
    while (!fs_b && n < 2100) begin
      @(negedge clk);
      n++;
    end
    chk("b_first_pulse_seen", 32'(fs_b), 32'd1);
    n      = 0;
    vs_low = 0;
    vb_hi  = 0;
    do begin
      if (!vs_b) vs_low++;
      if (vb_b) vb_hi++;
      @(negedge clk);
      n++;
    end while (!fs_b && n < 3000);
    chk("b_frame_period", 32'(n), 32'd1008);
    chk("b_vsync_low_cycles", 32'(vs_low), 32'd144);
    chk("b_vblank_high_cycles", 32'(vb_hi), 32'd432);

    // Mid-frame reset on the small raster, then scaling in Y and the next frame start.
    repeat ($urandom_range(100, 900)) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("b_midreset_hsync", 32'(hs_b), 32'd1);
    chk("b_midreset_de", 32'(de_b), 32'd0);
    chk("b_midreset_pxlX", 32'(x_b), 32'd0);
    chk("b_midreset_vblank", 32'(vb_b), 32'd0);
    rst_b = 1'b0;
    wait_k(1'b1, 64'd216);
    chk("b_pxlY_v3", 32'(y_b), 32'd0);
    wait_k(1'b1, 64'd504);
    chk("b_pxlY_v7", 32'(y_b), 32'd1);
    wait_k(1'b1, 64'd735);
    chk("b_pxlY_v10_clamped", 32'(y_b), 32'd1);
    chk("b_pxlX_h5", 32'(x_b), 32'd1);
    chk("b_vblank_v10", 32'(vb_b), 32'd1);
    wait_k(1'b1, 64'd1007);
    chk("b_frame_start_early", 32'(fs_b), 32'd0);
    wait_k(1'b1, 64'd1008);
    chk("b_frame_start_after_reset", 32'(fs_b), 32'd1);

    // Mid-line reset on the full-size raster.
    repeat ($urandom_range(200, 1500)) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("a_midreset_vsync", 32'(vs_a), 32'd1);
    chk("a_midreset_color", 32'(ocol_a), 32'd0);
    chk("a_midreset_pxlY", 32'(y_a), 32'd0);
    rst_a = 1'b0;

    // Random resets of random length on either instance; the per-cycle model does the checking.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      if ($urandom_range(0, 1) == 0) rst_a = 1'b1;
      else rst_b = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_a = 1'b0;
      rst_b = 1'b0;
    end
    repeat (3000) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
